// File: rtl/fft_mag_sq.sv
`timescale 1ns/1ps
// Power-spectrum stage: |X|^2 = re^2 + im^2 per FFT bin, tagged with bin index, last flag and frame count.
// Optional MAGSQ_SCALE_EN: round-half-up right shift of the sum by SCALE inside the output stage.
module fft_mag_sq #(
  parameter int IN_W     = 24,
  parameter int N_POINTS = 128,
  parameter int IDX_W    = 7,
  parameter int SCALE    = 2
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_sync,
  input  logic [IN_W-1:0]     i_re,
  input  logic [IN_W-1:0]     i_im,
  input  logic                i_data_valid,
  output logic                o_data_ready,
  output logic [2*IN_W-1:0]   o_data,
  output logic                o_data_valid,
  input  logic                i_data_ready,
  output logic [IDX_W-1:0]    o_index,
  output logic                o_last,
  output logic [1:0]          o_frame
);

  localparam int W = 2 * IN_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_POINTS - 1);

  logic en;
  logic accept;

  assign en           = !o_data_valid || i_data_ready;
  assign o_data_ready = en;
  assign accept       = i_data_valid && en;

  // ---------------------------------------------------------------
  // Bin / frame counters
  // ---------------------------------------------------------------
  logic [IDX_W-1:0] idx_reg, idx_next, tag_idx;
  logic [1:0]       frame_reg, frame_next, tag_frame;
  logic             tag_last;

  always_comb begin
    // A sync coinciding with an accept tags that very sample as bin 0 of frame 0.
    tag_idx    = i_sync ? '0 : idx_reg;
    tag_frame  = i_sync ? '0 : frame_reg;
    tag_last   = (tag_idx == LAST_IDX);
    idx_next   = idx_reg;
    frame_next = frame_reg;
    if (accept) begin
      if (tag_last) begin
        idx_next   = '0;
        frame_next = tag_frame + 2'd1;
      end else begin
        idx_next   = tag_idx + 1'b1;
        frame_next = tag_frame;
      end
    end else if (i_sync) begin
      idx_next   = '0;
      frame_next = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      idx_reg   <= '0;
      frame_reg <= '0;
    end else begin
      idx_reg   <= idx_next;
      frame_reg <= frame_next;
    end
  end

  // ---------------------------------------------------------------
  // Stage 1: squares
  // ---------------------------------------------------------------
  logic signed [W-1:0] re_ext, im_ext;
  logic signed [W-1:0] prod_re, prod_im;

  assign re_ext  = W'($signed(i_re));
  assign im_ext  = W'($signed(i_im));
  assign prod_re = re_ext * re_ext;
  assign prod_im = im_ext * im_ext;

  logic signed [W-1:0] sq_re_reg, sq_im_reg;
  logic [IDX_W-1:0]    s1_idx_reg;
  logic                s1_last_reg;
  logic [1:0]          s1_frame_reg;
  logic                v1_reg;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      v1_reg       <= 1'b0;
      sq_re_reg    <= '0;
      sq_im_reg    <= '0;
      s1_idx_reg   <= '0;
      s1_last_reg  <= 1'b0;
      s1_frame_reg <= '0;
    end else if (en) begin
      v1_reg <= accept;
      if (accept) begin
        sq_re_reg    <= prod_re;
        sq_im_reg    <= prod_im;
        s1_idx_reg   <= tag_idx;
        s1_last_reg  <= tag_last;
        s1_frame_reg <= tag_frame;
      end
    end
  end

  // ---------------------------------------------------------------
  // Stage 2: sum (and optional rounding shift)
  // ---------------------------------------------------------------
  // Squares are never negative, so each product's sign bit is dropped;
  // the largest sum, 2^(W-1), still fits W bits unsigned.
  logic [W-1:0] sum;
  logic [W-1:0] mag;

  assign sum = W'(sq_re_reg[W-2:0]) + W'(sq_im_reg[W-2:0]);

`ifdef MAGSQ_SCALE_EN
  localparam logic [W:0] RND = (SCALE > 0) ? ((W+1)'(1) << (SCALE - 1)) : '0;
  logic [W:0] rnd_sum;
  logic [W:0] shifted;

  assign rnd_sum = {1'b0, sum} + RND;
  assign shifted = rnd_sum >> SCALE;
  assign mag     = shifted[W-1:0];

  logic unused_bits;
  assign unused_bits = ^{sq_re_reg[W-1], sq_im_reg[W-1], shifted[W]};
`else
  localparam int unused_scale = SCALE;
  assign mag = sum;

  logic unused_bits;
  assign unused_bits = ^{sq_re_reg[W-1], sq_im_reg[W-1]};
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_data_valid <= 1'b0;
      o_data       <= '0;
      o_index      <= '0;
      o_last       <= 1'b0;
      o_frame      <= '0;
    end else if (en) begin
      o_data_valid <= v1_reg;
      // Data and tags only move with a real sample; bubbles leave them untouched.
      if (v1_reg) begin
        o_data  <= mag;
        o_index <= s1_idx_reg;
        o_last  <= s1_last_reg;
        o_frame <= s1_frame_reg;
      end
    end
  end

endmodule

// File: tb/tb_fft_mag_sq.sv
`timescale 1ns/1ps
// Scoreboard bench for fft_mag_sq: spec-level model pushes expectations, a monitor pops on each output transfer.
module tb_fft_mag_sq;

  localparam int IN_W     = 24;
  localparam int N_POINTS = 128;
  localparam int IDX_W    = 7;
  localparam int SCALE    = 2;
  localparam int W        = 2 * IN_W;

  logic              i_clk = 1'b0;
  logic              i_rst_n = 1'b0;
  logic              i_sync = 1'b0;
  logic [IN_W-1:0]   i_re = '0;
  logic [IN_W-1:0]   i_im = '0;
  logic              i_data_valid = 1'b0;
  logic              o_data_ready;
  logic [W-1:0]      o_data;
  logic              o_data_valid;
  logic              i_data_ready = 1'b1;
  logic [IDX_W-1:0]  o_index;
  logic              o_last;
  logic [1:0]        o_frame;

  fft_mag_sq #(.IN_W(IN_W), .N_POINTS(N_POINTS), .IDX_W(IDX_W), .SCALE(SCALE)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_sync(i_sync), .i_re(i_re), .i_im(i_im),
    .i_data_valid(i_data_valid), .o_data_ready(o_data_ready), .o_data(o_data),
    .o_data_valid(o_data_valid), .i_data_ready(i_data_ready), .o_index(o_index),
    .o_last(o_last), .o_frame(o_frame)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [W-1:0]     data;
    logic [IDX_W-1:0] idx;
    logic             last;
    logic [1:0]       frame;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   m_idx = 0;
  int   m_frame = 0;
  bit   rand_ready = 0;
  logic ready_cmd = 1'b1;

  // Monitor-side history for the hold-while-stalled check
  bit               stall_prev = 0;
  logic [W-1:0]     prev_data;
  logic [IDX_W-1:0] prev_index;
  logic             prev_last;
  logic [1:0]       prev_frame;
  exp_t             e;
  int               ti, tf;

  function automatic logic [W-1:0] ref_mag(input logic [IN_W-1:0] re, input logic [IN_W-1:0] im);
    longint r, i, s;
    r = longint'($signed(re));
    i = longint'($signed(im));
    s = r * r + i * i;
`ifdef MAGSQ_SCALE_EN
    s = (s + (longint'(1) << (SCALE - 1))) >>> SCALE;
`endif
    return W'(s);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Ready driver: either commanded level or random per cycle
  always @(posedge i_clk) begin
    #1;
    i_data_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_cmd;
  end

  // Reference model + scoreboard monitor, sampled mid-cycle
  always @(negedge i_clk) begin
    if (!i_rst_n) begin
      sb.delete();
      m_idx = 0;
      m_frame = 0;
      stall_prev = 0;
    end else begin
      chk("ready_rule", 64'(o_data_ready), 64'(!o_data_valid || i_data_ready));
      if (stall_prev) begin
        chk("hold_valid", 64'(o_data_valid), 64'(1));
        chk("hold_data", 64'(o_data), 64'(prev_data));
        chk("hold_index", 64'(o_index), 64'(prev_index));
        chk("hold_tags", 64'({o_last, o_frame}), 64'({prev_last, prev_frame}));
      end
      if (o_data_valid && i_data_ready) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output actual=idx%0d expected=no_output t=%0t", o_index, $time);
        end else begin
          e = sb.pop_front();
          chk("data", 64'(o_data), 64'(e.data));
          chk("index", 64'(o_index), 64'(e.idx));
          chk("last", 64'(o_last), 64'(e.last));
          chk("frame", 64'(o_frame), 64'(e.frame));
          $display("OUT idx=%0d frame=%0d last=%0d data=%0h", o_index, o_frame, o_last, o_data);
        end
      end
      if (i_data_valid && o_data_ready) begin
        ti = i_sync ? 0 : m_idx;
        tf = i_sync ? 0 : m_frame;
        sb.push_back('{data: ref_mag(i_re, i_im), idx: IDX_W'(ti),
                       last: (ti == N_POINTS - 1), frame: 2'(tf)});
        if (ti == N_POINTS - 1) begin
          m_idx = 0;
          m_frame = (tf + 1) % 4;
        end else begin
          m_idx = ti + 1;
          m_frame = tf;
        end
      end else if (i_sync) begin
        m_idx = 0;
        m_frame = 0;
      end
      stall_prev = o_data_valid && !i_data_ready;
      prev_data  = o_data;
      prev_index = o_index;
      prev_last  = o_last;
      prev_frame = o_frame;
    end
  end

  task automatic cycle();
    @(posedge i_clk);
    #1;
  endtask

  // Present a sample and hold it until the DUT takes it
  task automatic send(input logic [IN_W-1:0] re, input logic [IN_W-1:0] im, input logic sync);
    bit acc;
    acc = 0;
    i_re = re;
    i_im = im;
    i_sync = sync;
    i_data_valid = 1'b1;
    for (int n = 0; n < 200 && !acc; n++) begin
      @(negedge i_clk);
      acc = o_data_ready;
      @(posedge i_clk);
      #1;
    end
    if (!acc) begin
      checks++;
      failures++;
      $display("FAIL send_timeout actual=not_accepted expected=accepted t=%0t", $time);
    end
    i_sync = 1'b0;
    i_data_valid = 1'b0;
  endtask

  function automatic logic [IN_W-1:0] rand_sample();
    case ($urandom_range(0, 5))
      0: return {1'b1, {(IN_W-1){1'b0}}};
      1: return {1'b0, {(IN_W-1){1'b1}}};
      2: return '0;
      default: return IN_W'($urandom);
    endcase
  endfunction

  logic [W-1:0] corner_exp;

  initial begin
`ifdef MAGSQ_SCALE_EN
    corner_exp = 48'h2000_0000_0000;
`else
    corner_exp = 48'h8000_0000_0000;
`endif
    // Reset state
    repeat (3) cycle();
    chk("rst_valid", 64'(o_data_valid), 64'(0));
    chk("rst_data", 64'(o_data), 64'(0));
    chk("rst_tags", 64'({o_index, o_last, o_frame}), 64'(0));
    chk("rst_ready", 64'(o_data_ready), 64'(1));
    i_rst_n = 1'b1;
    cycle();

    // First sample: 3 - 4j -> 25 after two cycles
    send(24'd3, 24'hFFFFFC, 1'b0);
    chk("lat1_valid", 64'(o_data_valid), 64'(0));
    cycle();
    chk("lat2_valid", 64'(o_data_valid), 64'(1));
`ifdef MAGSQ_SCALE_EN
    chk("first_data", 64'(o_data), 64'(6));
`else
    chk("first_data", 64'(o_data), 64'(25));
`endif
    chk("first_tags", 64'({o_index, o_last, o_frame}), 64'(0));

    // Most negative corner on both parts
    send(24'h800000, 24'h800000, 1'b0);
    cycle();
    chk("corner_data", 64'(o_data), 64'(corner_exp));

    // Four full frames plus two bins, back to back
    send(rand_sample(), rand_sample(), 1'b1);
    for (int k = 1; k < 4 * N_POINTS + 2; k++) send(rand_sample(), rand_sample(), 1'b0);
    repeat (4) cycle();

    // Stall after three accepts
    send(24'd1, 24'd1, 1'b1);
    send(24'd2, 24'd2, 1'b0);
    send(24'd3, 24'd3, 1'b0);
    ready_cmd = 1'b0;
    repeat (6) cycle();
    chk("stall_ready", 64'(o_data_ready), 64'(0));
    chk("stall_valid", 64'(o_data_valid), 64'(1));
    ready_cmd = 1'b1;
    repeat (4) cycle();

    // Sync arriving when the counter sits at 57
    send(rand_sample(), rand_sample(), 1'b1);
    for (int k = 1; k < 57; k++) send(rand_sample(), rand_sample(), 1'b0);
    send(24'd7, 24'd0, 1'b1);
    send(24'd8, 24'd0, 1'b0);
    cycle();
    chk("sync_next_index", 64'(o_index), 64'(1));
    repeat (3) cycle();

    // Reset mid-frame with two samples in flight
    send(24'd10, 24'd10, 1'b0);
    send(24'd11, 24'd11, 1'b0);
    i_rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 64'(o_data_valid), 64'(0));
    repeat (2) cycle();
    i_rst_n = 1'b1;
    cycle();
    send(24'd5, 24'd12, 1'b0);
    cycle();
    chk("post_rst_valid", 64'(o_data_valid), 64'(1));
    chk("post_rst_index", 64'(o_index), 64'(0));

    // Randomized valid, ready and occasional sync
    rand_ready = 1;
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 3) != 0)
        send(rand_sample(), rand_sample(), 1'($urandom_range(0, 63) == 0));
      else
        cycle();
    end
    rand_ready = 0;
    ready_cmd = 1'b1;

    // Drain with a bounded wait
    for (int k = 0; k < 500 && sb.size() > 0; k++) cycle();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d_pending expected=0_pending", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
